// File: rtl/ica_bus_arbiter.sv
// rtl/ica_bus_arbiter.sv - two-requester arbiter for the shared ICA/DCA memory bus
//
// Arbitrates two burst requesters (ICA/DCA unit 0 and unit 1) onto a single
// memory bus. Urgent requests beat normal ones; ties are broken round-robin.
// Every bus cycle ends on mem_bus_ack or on a timeout, followed by one
// RELEASE cycle so requesters can settle before the next arbitration.
//
// Parameters
//   TIMEOUT_CYCLES        grant cycles without mem_bus_ack before forced release (1..255)
//
// Ports
//   clk                   system clock, rising edge
//   reset_n               asynchronous active-low reset
//   req0_address          requester 0 byte address
//   req0_as               requester 0 address strobe (request)
//   req0_urgent           requester 0 high priority
//   req0_bus_ack          mem_bus_ack routed to requester 0 while it owns the bus
//   req0_burstdata_valid  mem_burstdata_valid routed to requester 0 while it owns the bus
//   req1_*                same set for requester 1
//   req_din               mem_din broadcast to both requesters
//   mem_address           shared bus address, latched at grant
//   mem_as                shared bus address strobe
//   mem_din               shared bus read data
//   mem_bus_ack           shared bus cycle end
//   mem_burstdata_valid   shared bus read word valid
//   grant                 one-hot current owner (bit0 = requester 0), 00 when none
//   timeout_err           one-cycle pulse on forced release

module ica_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [21:0] req0_address,
    input  logic        req0_as,
    input  logic        req0_urgent,
    output logic        req0_bus_ack,
    output logic        req0_burstdata_valid,
    input  logic [21:0] req1_address,
    input  logic        req1_as,
    input  logic        req1_urgent,
    output logic        req1_bus_ack,
    output logic        req1_burstdata_valid,
    output logic [15:0] req_din,
    output logic [21:0] mem_address,
    output logic        mem_as,
    input  logic [15:0] mem_din,
    input  logic        mem_bus_ack,
    input  logic        mem_burstdata_valid,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [21:0] address_next;
    logic [7:0]  tmo_cnt;
    logic [7:0]  tmo_cnt_next;
    logic        last_grant;
    logic        last_grant_next;
    logic        timeout_err_next;
    logic [1:0]  grant_next;
    logic        mem_as_next;

    logic        urgent0;
    logic        urgent1;
    logic        win0;
    logic        win1;

    // Arbitration on the current cycle's requests. Urgency is compared first;
    // only requests of equal standing fall through to the as/round-robin tiers.
    always_comb begin
        urgent0 = req0_as & req0_urgent;
        urgent1 = req1_as & req1_urgent;
        win0    = 1'b0;
        win1    = 1'b0;
        if (urgent0 != urgent1) begin
            win0 = urgent0;
            win1 = urgent1;
        end else if (req0_as != req1_as) begin
            win0 = req0_as;
            win1 = req1_as;
        end else if (req0_as) begin
            // last_grant names the previous winner; the other side gets the tie.
            win0 = last_grant;
            win1 = ~last_grant;
        end
    end

    always_comb begin
        state_next       = state;
        address_next     = mem_address;
        tmo_cnt_next     = tmo_cnt;
        last_grant_next  = last_grant;
        timeout_err_next = 1'b0;

        case (state)
            IDLE: begin
                if (win0) begin
                    state_next      = GRANT0;
                    address_next    = req0_address;
                    last_grant_next = 1'b0;
                    tmo_cnt_next    = 8'd0;
                end else if (win1) begin
                    state_next      = GRANT1;
                    address_next    = req1_address;
                    last_grant_next = 1'b1;
                    tmo_cnt_next    = 8'd0;
                end
            end
            GRANT0, GRANT1: begin
                // Ack is tested first so an ack on the timeout cycle is a
                // normal completion, not an error.
                if (mem_bus_ack) begin
                    state_next = RELEASE;
                end else if (tmo_cnt == TIMEOUT_LIMIT) begin
                    state_next       = RELEASE;
                    timeout_err_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt + 8'd1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        grant_next  = {state_next == GRANT1, state_next == GRANT0};
        mem_as_next = |grant_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_address <= 22'd0;
            mem_as      <= 1'b0;
            grant       <= 2'b00;
            tmo_cnt     <= 8'd0;
            last_grant  <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            mem_address <= address_next;
            mem_as      <= mem_as_next;
            grant       <= grant_next;
            tmo_cnt     <= tmo_cnt_next;
            last_grant  <= last_grant_next;
            timeout_err <= timeout_err_next;
        end
    end

    // Strobes reach only the current owner; reset_n gating keeps them quiet
    // during reset regardless of what the memory side is doing.
    assign req0_bus_ack         = reset_n & (state == GRANT0) & mem_bus_ack;
    assign req0_burstdata_valid = reset_n & (state == GRANT0) & mem_burstdata_valid;
    assign req1_bus_ack         = reset_n & (state == GRANT1) & mem_bus_ack;
    assign req1_burstdata_valid = reset_n & (state == GRANT1) & mem_burstdata_valid;
    assign req_din              = mem_din;

endmodule

// File: tb/tb_ica_bus_arbiter.sv
// tb/tb_ica_bus_arbiter.sv - self-checking bench for ica_bus_arbiter

module tb_ica_bus_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        reset_n;
    logic [21:0] req0_address;
    logic        req0_as;
    logic        req0_urgent;
    logic        req0_bus_ack;
    logic        req0_burstdata_valid;
    logic [21:0] req1_address;
    logic        req1_as;
    logic        req1_urgent;
    logic        req1_bus_ack;
    logic        req1_burstdata_valid;
    logic [15:0] req_din;
    logic [21:0] mem_address;
    logic        mem_as;
    logic [15:0] mem_din;
    logic        mem_bus_ack;
    logic        mem_burstdata_valid;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    ica_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req0_address         (req0_address),
        .req0_as              (req0_as),
        .req0_urgent          (req0_urgent),
        .req0_bus_ack         (req0_bus_ack),
        .req0_burstdata_valid (req0_burstdata_valid),
        .req1_address         (req1_address),
        .req1_as              (req1_as),
        .req1_urgent          (req1_urgent),
        .req1_bus_ack         (req1_bus_ack),
        .req1_burstdata_valid (req1_burstdata_valid),
        .req_din              (req_din),
        .mem_address          (mem_address),
        .mem_as               (mem_as),
        .mem_din              (mem_din),
        .mem_bus_ack          (mem_bus_ack),
        .mem_burstdata_valid  (mem_burstdata_valid),
        .grant                (grant),
        .timeout_err          (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_address        = 22'd0;
        req0_as             = 1'b0;
        req0_urgent         = 1'b0;
        req1_address        = 22'd0;
        req1_as             = 1'b0;
        req1_urgent         = 1'b0;
        mem_din             = 16'd0;
        mem_bus_ack         = 1'b0;
        mem_burstdata_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        req0_as             = 1'b1;
        req1_as             = 1'b1;
        mem_bus_ack         = 1'b1;
        mem_burstdata_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_as, grant, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {mem_as, grant, timeout_err});
        end
        checks++;
        if (mem_address !== 22'd0) begin
            errors++;
            $display("FAIL reset_address: got %h expected 0", mem_address);
        end
        checks++;
        if ({req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid});
        end
        clear_inputs();
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_as, grant} !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_request: got %b expected 000", {mem_as, grant});
        end
    endtask

    task automatic test_single();
        int valid_seen;
        int ack_seen;
        logic [15:0] din;
        valid_seen = 0;
        ack_seen   = 0;
        req0_address = 22'h400;
        req0_as      = 1'b1;
        tick();
        checks++;
        if ({mem_as, grant} !== 3'b101 || mem_address !== 22'h400) begin
            errors++;
            $display("FAIL single_grant: got as=%b grant=%b addr=%h expected as=1 grant=01 addr=400",
                     mem_as, grant, mem_address);
        end
        req0_as      = 1'b0;
        req0_address = 22'h155;
        for (int i = 0; i < 3; i++) begin
            din                 = 16'($urandom);
            mem_din             = din;
            mem_burstdata_valid = (i < 2);
            mem_bus_ack         = (i == 2);
            #1;
            checks++;
            if ({req1_bus_ack, req1_burstdata_valid} !== 2'b00 || req_din !== din) begin
                errors++;
                $display("FAIL single_routing: got req1=%b din=%h expected req1=00 din=%h",
                         {req1_bus_ack, req1_burstdata_valid}, req_din, din);
            end
            valid_seen += int'(req0_burstdata_valid);
            ack_seen   += int'(req0_bus_ack);
            tick();
            if (i < 2) begin
                checks++;
                if (mem_as !== 1'b1 || mem_address !== 22'h400) begin
                    errors++;
                    $display("FAIL single_stable: got as=%b addr=%h expected as=1 addr=400",
                             mem_as, mem_address);
                end
            end
        end
        mem_burstdata_valid = 1'b0;
        mem_bus_ack         = 1'b0;
        checks++;
        if ({mem_as, grant} !== 3'b000) begin
            errors++;
            $display("FAIL single_release: got %b expected 000", {mem_as, grant});
        end
        checks++;
        if (valid_seen != 2 || ack_seen != 1) begin
            errors++;
            $display("FAIL single_counts: got valids=%0d acks=%0d expected 2 and 1", valid_seen, ack_seen);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [3];
        int lat;
        exp_g[0] = 2'b01;
        exp_g[1] = 2'b10;
        exp_g[2] = 2'b01;
        apply_reset();
        req0_address = 22'h0aaaa;
        req1_address = 22'h15555;
        req0_as      = 1'b1;
        req1_as      = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (grant !== exp_g[i] || mem_as !== 1'b1 ||
                mem_address !== ((exp_g[i] == 2'b01) ? 22'h0aaaa : 22'h15555)) begin
                errors++;
                $display("FAIL rr_grant%0d: got grant=%b as=%b addr=%h expected grant=%b as=1",
                         i, grant, mem_as, mem_address, exp_g[i]);
            end
            mem_bus_ack = 1'b1;
            tick();
            mem_bus_ack = 1'b0;
            if (i < 2) begin
                lat = 1;
                while (mem_as !== 1'b1 && lat < 8) begin
                    tick();
                    lat++;
                end
                checks++;
                if (lat != 3) begin
                    errors++;
                    $display("FAIL rr_latency%0d: got %0d edges expected 3", i, lat);
                end
            end else begin
                req0_as = 1'b0;
                req1_as = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_urgent();
        logic       u0_t [5];
        logic       u1_t [5];
        logic [1:0] g_t  [5];
        u0_t[0] = 1'b0; u1_t[0] = 1'b1; g_t[0] = 2'b10;
        u0_t[1] = 1'b0; u1_t[1] = 1'b1; g_t[1] = 2'b10;
        u0_t[2] = 1'b0; u1_t[2] = 1'b0; g_t[2] = 2'b01;
        u0_t[3] = 1'b1; u1_t[3] = 1'b0; g_t[3] = 2'b01;
        u0_t[4] = 1'b1; u1_t[4] = 1'b1; g_t[4] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            req0_as     = 1'b1;
            req1_as     = 1'b1;
            req0_urgent = u0_t[i];
            req1_urgent = u1_t[i];
            tick();
            checks++;
            if (grant !== g_t[i]) begin
                errors++;
                $display("FAIL urgent_case%0d: got grant=%b expected %b", i, grant, g_t[i]);
            end
            clear_inputs();
            mem_bus_ack = 1'b1;
            tick();
            mem_bus_ack = 1'b0;
            tick();
        end
    endtask

    task automatic test_timeout();
        req0_address = 22'h2345;
        req0_as      = 1'b1;
        tick();
        req0_as = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            mem_burstdata_valid = 1'($urandom);
            #1;
            checks++;
            if (req0_bus_ack !== 1'b0 || req0_burstdata_valid !== mem_burstdata_valid) begin
                errors++;
                $display("FAIL timeout_strobes%0d: got ack=%b valid=%b expected ack=0 valid=%b",
                         k, req0_bus_ack, req0_burstdata_valid, mem_burstdata_valid);
            end
            tick();
            checks++;
            if (k < 5 && {mem_as, grant, timeout_err} !== 4'b1010) begin
                errors++;
                $display("FAIL timeout_wait%0d: got %b expected 1010", k, {mem_as, grant, timeout_err});
            end else if (k == 5 && {mem_as, grant, timeout_err} !== 4'b0001) begin
                errors++;
                $display("FAIL timeout_fire: got %b expected 0001", {mem_as, grant, timeout_err});
            end
        end
        mem_burstdata_valid = 1'b0;
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: got %b expected 0", timeout_err);
        end
        req0_address = 22'h3abc;
        req0_as      = 1'b1;
        tick();
        req0_as     = 1'b0;
        mem_bus_ack = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b01 || mem_address !== 22'h3abc || req0_bus_ack !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover: got grant=%b addr=%h ack=%b expected 01 3abc 1",
                     grant, mem_address, req0_bus_ack);
        end
        tick();
        mem_bus_ack = 1'b0;
        tick();
        req1_as = 1'b1;
        tick();
        req1_as = 1'b0;
        repeat (4) tick();
        mem_bus_ack = 1'b1;
        #1;
        checks++;
        if (req1_bus_ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_at_limit_forward: got %b expected 1", req1_bus_ack);
        end
        tick();
        mem_bus_ack = 1'b0;
        checks++;
        if ({mem_as, grant, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL ack_beats_timeout: got %b expected 0000", {mem_as, grant, timeout_err});
        end
        tick();
    endtask

    task automatic test_ignore();
        req1_as = 1'b1;
        tick();
        mem_bus_ack = 1'b1;
        tick();
        mem_burstdata_valid = 1'b1;
        #1;
        checks++;
        if ({req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid} !== 4'b0000 ||
            mem_as !== 1'b0) begin
            errors++;
            $display("FAIL release_ignore: got strobes=%b as=%b expected 0000 0",
                     {req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid}, mem_as);
        end
        tick();
        checks++;
        if (mem_as !== 1'b0) begin
            errors++;
            $display("FAIL release_one_cycle: got as=%b expected 0", mem_as);
        end
        req1_as = 1'b0;
        #1;
        checks++;
        if ({req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ignore: got %b expected 0000",
                     {req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid});
        end
        tick();
        clear_inputs();
        checks++;
        if ({mem_as, grant} !== 3'b000) begin
            errors++;
            $display("FAIL idle_stays: got %b expected 000", {mem_as, grant});
        end
    endtask

    task automatic test_reset_mid();
        req1_address = 22'h1f0f0;
        req1_as      = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_grant: got %b expected 10", grant);
        end
        req1_as             = 1'b0;
        mem_burstdata_valid = 1'b1;
        mem_bus_ack         = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_as, grant} !== 3'b000 || mem_address !== 22'd0 ||
            {req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_async: got as/grant=%b addr=%h strobes=%b expected 000 0 0000",
                     {mem_as, grant}, mem_address,
                     {req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid});
        end
        clear_inputs();
        tick();
        reset_n = 1'b1;
        req0_as = 1'b1;
        req1_as = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_restart: got %b expected 01", grant);
        end
        clear_inputs();
        mem_bus_ack = 1'b1;
        tick();
        mem_bus_ack = 1'b0;
        tick();
    endtask

    // Reference model: owner (-1 = bus free), grant age in non-ack cycles,
    // a one-cycle cool-down after each release, and the previous winner.
    task automatic test_random();
        int owner;
        int age;
        int cool;
        int last;
        int winner;
        int s0;
        int s1;
        logic [21:0] exp_addr;
        logic        exp_terr;
        logic [1:0]  exp_grant;
        apply_reset();
        owner    = -1;
        age      = 0;
        cool     = 0;
        last     = 1;
        exp_addr = 22'd0;
        exp_terr = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            req0_as             = ($urandom % 3) != 0;
            req1_as             = ($urandom % 3) != 0;
            req0_urgent         = ($urandom % 4) == 0;
            req1_urgent         = ($urandom % 4) == 0;
            req0_address        = 22'($urandom);
            req1_address        = 22'($urandom);
            mem_din             = 16'($urandom);
            mem_burstdata_valid = 1'($urandom);
            mem_bus_ack         = ($urandom % 5) == 0;
            #1;
            exp_grant = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
            checks++;
            if (grant !== exp_grant || mem_as !== (owner >= 0)) begin
                errors++;
                $display("FAIL rand_grant @%0d: got grant=%b as=%b expected grant=%b as=%b",
                         n, grant, mem_as, exp_grant, owner >= 0);
            end
            checks++;
            if (mem_address !== exp_addr) begin
                errors++;
                $display("FAIL rand_address @%0d: got %h expected %h", n, mem_address, exp_addr);
            end
            checks++;
            if (timeout_err !== exp_terr) begin
                errors++;
                $display("FAIL rand_timeout_err @%0d: got %b expected %b", n, timeout_err, exp_terr);
            end
            checks++;
            if (req0_bus_ack !== (owner == 0 && mem_bus_ack) ||
                req0_burstdata_valid !== (owner == 0 && mem_burstdata_valid) ||
                req1_bus_ack !== (owner == 1 && mem_bus_ack) ||
                req1_burstdata_valid !== (owner == 1 && mem_burstdata_valid)) begin
                errors++;
                $display("FAIL rand_strobes @%0d: got %b owner=%0d ack=%b valid=%b",
                         n, {req0_bus_ack, req0_burstdata_valid, req1_bus_ack, req1_burstdata_valid},
                         owner, mem_bus_ack, mem_burstdata_valid);
            end
            checks++;
            if (req_din !== mem_din) begin
                errors++;
                $display("FAIL rand_din @%0d: got %h expected %h", n, req_din, mem_din);
            end
            exp_terr = 1'b0;
            if (cool != 0) begin
                cool = 0;
            end else if (owner >= 0) begin
                if (mem_bus_ack) begin
                    owner = -1;
                    cool  = 1;
                end else if (age == TO) begin
                    owner    = -1;
                    cool     = 1;
                    exp_terr = 1'b1;
                end else begin
                    age++;
                end
            end else begin
                s0 = req0_as ? (req0_urgent ? 2 : 1) : 0;
                s1 = req1_as ? (req1_urgent ? 2 : 1) : 0;
                if (s0 + s1 > 0) begin
                    if (s0 > s1)      winner = 0;
                    else if (s1 > s0) winner = 1;
                    else              winner = 1 - last;
                    owner    = winner;
                    last     = winner;
                    age      = 0;
                    exp_addr = (winner == 0) ? req0_address : req1_address;
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_urgent();
        test_timeout();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
